// File: rtl/pixel_io_pkg.sv
// rtl/pixel_io_pkg.sv - shared image geometry and serializer state encoding
//
// Purpose: constants common to the pixel loader and pixel serializer, plus
//          the serializer FSM state type.
// Ports:   none (package).
package pixel_io_pkg;

  localparam int IMG_DIM  = 28;
  localparam int N_PIXELS = IMG_DIM * IMG_DIM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/bit_period_divider.sv
// rtl/bit_period_divider.sv - divides the clock into DIV-cycle serial bit periods
//
// Purpose: counts clock cycles within one serial bit period.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   clr           start a new image: counter to 0, next cycle is a period start
//   en            advance the counter (a further period follows this one)
//   first         registered, high on the first cycle of each bit period
//   last          combinational, high on the final cycle of the current period
module bit_period_divider #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic first,
  output logic last
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;

  assign last  = (cnt_q == LAST_CNT);
  assign first = first_q;

  // first_d flags that the coming cycle opens a new period; with DIV=1
  // every enabled cycle is both first and last.
  always_comb begin
    cnt_d   = cnt_q;
    first_d = 1'b0;
    if (clr) begin
      cnt_d   = '0;
      first_d = 1'b1;
    end else if (en) begin
      first_d = last;
      cnt_d   = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

endmodule

// File: rtl/pixel_serializer.sv
// rtl/pixel_serializer.sv - shifts one binarized image out on a serial line
//
// Purpose: accepts an N_BITS image over valid/ready and sends it LSB (pixel 0)
//          first, DIV clocks per bit, then pulses tx_done for one cycle.
// Option:  PIXEL_TX_ONES_COUNT_EN enables the ones_count counter; otherwise
//          ones_count is tied to 0.
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   img_valid/img_ready   image handshake; img_data captured on acceptance
//   img_data              image, bit k = pixel k
//   d_out_p               serial pixel bit
//   bit_strobe            first cycle of each bit period
//   tx_busy               bits on the line
//   tx_done               one-cycle pulse after the last bit period
//   ones_count            number of 1-bits sent in the current image
module pixel_serializer
  import pixel_io_pkg::*;
#(
  parameter int N_BITS = N_PIXELS,
  parameter int DIV    = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        img_valid,
  output logic                        img_ready,
  input  logic [N_BITS-1:0]           img_data,
  output logic                        d_out_p,
  output logic                        bit_strobe,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(N_BITS+1)-1:0] ones_count
);

  localparam int            BW        = $clog2(N_BITS);
  localparam int            OW        = $clog2(N_BITS + 1);
  localparam logic [BW-1:0] FINAL_BIT = BW'(N_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [N_BITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              d_out_p_q, d_out_p_d;
  logic              tx_busy_q, tx_busy_d;
  logic              tx_done_q, tx_done_d;

  logic clr, period_last, tx_end, div_en;

  assign img_ready = (state_q == IDLE);
  assign clr       = img_ready && img_valid;
  assign tx_end    = (state_q == SEND) && period_last && (bit_cnt_q == FINAL_BIT);
  // Stopping the divider on the final period keeps bit_strobe low in DONE.
  assign div_en    = (state_q == SEND) && !tx_end;

  bit_period_divider #(.DIV(DIV)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .en      (div_en),
    .first   (bit_strobe),
    .last    (period_last)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (img_valid) begin
          state_d   = SEND;
          shreg_d   = img_data;
          bit_cnt_d = '0;
        end
      end
      SEND: begin
        if (period_last) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == FINAL_BIT) state_d = DONE;
          else                        bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next-state view so they line up with
    // the state they describe.
    d_out_p_d = (state_d == SEND) ? shreg_d[0] : 1'b0;
    tx_busy_d = (state_d == SEND);
    tx_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      d_out_p_q <= 1'b0;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      d_out_p_q <= d_out_p_d;
      tx_busy_q <= tx_busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign d_out_p = d_out_p_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

`ifdef PIXEL_TX_ONES_COUNT_EN
  logic [OW-1:0] ones_q, ones_d;

  // Counts the bit presented in the previous strobe cycle, so the final
  // total is visible in the tx_done cycle and held until the next image.
  always_comb begin
    ones_d = ones_q;
    if (clr)                            ones_d = '0;
    else if (bit_strobe && d_out_p_q)   ones_d = ones_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ones_q <= '0;
    else          ones_q <= ones_d;
  end

  assign ones_count = ones_q;
`else
  assign ones_count = '0;
`endif

endmodule

// File: tb/tb_pixel_serializer.sv
// tb/tb_pixel_serializer.sv - scoreboard bench for pixel_serializer (DIV=1 and DIV=4)
module tb_pixel_serializer;

  localparam int N  = 784;
  localparam int OW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sel = 1'b0;
  logic          tb_valid = 1'b0;
  logic [N-1:0]  tb_data = '0;

  logic          v1, r1, d1, s1, b1, t1;
  logic          v4, r4, d4, s4, b4, t4;
  logic [OW-1:0] o1, o4;

  logic          o_ready, o_dout, o_strobe, o_busy, o_done;
  logic [OW-1:0] o_ones;

  int n_cmp  = 0;
  int n_fail = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  assign v1 = tb_valid && !sel;
  assign v4 = tb_valid && sel;

  pixel_serializer #(.N_BITS(N), .DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .img_valid(v1), .img_ready(r1), .img_data(tb_data),
    .d_out_p(d1), .bit_strobe(s1), .tx_busy(b1), .tx_done(t1), .ones_count(o1)
  );

  pixel_serializer #(.N_BITS(N), .DIV(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .img_valid(v4), .img_ready(r4), .img_data(tb_data),
    .d_out_p(d4), .bit_strobe(s4), .tx_busy(b4), .tx_done(t4), .ones_count(o4)
  );

  assign o_ready  = sel ? r4 : r1;
  assign o_dout   = sel ? d4 : d1;
  assign o_strobe = sel ? s4 : s1;
  assign o_busy   = sel ? b4 : b1;
  assign o_done   = sel ? t4 : t1;
  assign o_ones   = sel ? o4 : o1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ones_model(input logic [N-1:0] data);
`ifdef PIXEL_TX_ONES_COUNT_EN
    return 32'($countones(data));
`else
    return 32'(0 * $countones(data));
`endif
  endfunction

  // Handshake in the coming cycle T, then check every cycle through T+N*div+2.
  task automatic send_image(input logic [N-1:0] data, input int div,
                            input bit keep_valid, input bit change_data,
                            input logic [N-1:0] alt_data);
    logic        cur = 1'b0;
    logic [31:0] ones_exp;
    bit          busy_e, strobe_e, done_e, ready_e;
    ones_exp = ones_model(data);
    check("ready_before_hs", 32'(o_ready), 32'd1);
    tb_data  = data;
    tb_valid = 1'b1;
    for (int k = 0; k < N; k++) exp_q.push_back(data[k]);
    @(posedge clk);
    for (int cyc = 1; cyc <= N * div + 2; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        if (!keep_valid) tb_valid = 1'b0;
        if (change_data) tb_data = alt_data;
      end
      busy_e   = (cyc <= N * div);
      strobe_e = busy_e && (((cyc - 1) % div) == 0);
      done_e   = (cyc == N * div + 1);
      ready_e  = (cyc == N * div + 2);
      if (strobe_e) cur = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      check("d_out_p",    32'(o_dout),   32'(busy_e ? cur : 1'b0));
      check("bit_strobe", 32'(o_strobe), 32'(strobe_e));
      check("tx_busy",    32'(o_busy),   32'(busy_e));
      check("tx_done",    32'(o_done),   32'(done_e));
      check("img_ready",  32'(o_ready),  32'(ready_e));
      if (done_e || ready_e) check("ones_count", 32'(o_ones), ones_exp);
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [N-1:0] rand_img();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  initial begin
    logic [N-1:0] img_a, img_b, img_c, img_r, img_z;
    img_z = '0;
    for (int k = 0; k < N; k++) img_a[k] = 1'(k % 2);
    img_b = rand_img();
    img_c = rand_img();
    img_r = rand_img();

    // Reset values on both instances.
    repeat (3) @(negedge clk);
    check("rst_ready1", 32'(r1), 32'd1);
    check("rst_dout1",  32'(d1), 32'd0);
    check("rst_strb1",  32'(s1), 32'd0);
    check("rst_busy1",  32'(b1), 32'd0);
    check("rst_done1",  32'(t1), 32'd0);
    check("rst_ones1",  32'(o1), 32'd0);
    check("rst_ready4", 32'(r4), 32'd1);
    check("rst_busy4",  32'(b4), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Alternating image, DIV=1.
    send_image(img_a, 1, 1'b0, 1'b0, img_z);

    // Valid held through SEND, data changed after handshake; second image
    // must be taken in cycle T+786.
    send_image(img_b, 1, 1'b1, 1'b1, img_c);
    send_image(img_c, 1, 1'b0, 1'b0, img_z);

    // Reset in the middle of bit 300.
    tb_data  = img_r;
    tb_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_valid = 1'b0;
    repeat (300) @(negedge clk);
    check("mid_busy", 32'(o_busy), 32'd1);
    check("mid_bit300", 32'(o_dout), 32'(img_r[300]));
    #2 reset_n = 1'b0;
    #1;
    check("arst_dout",  32'(o_dout),   32'd0);
    check("arst_strb",  32'(o_strobe), 32'd0);
    check("arst_busy",  32'(o_busy),   32'd0);
    check("arst_done",  32'(o_done),   32'd0);
    check("arst_ready", 32'(o_ready),  32'd1);
    check("arst_ones",  32'(o_ones),   32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_done", 32'(o_done), 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_done", 32'(o_done), 32'd0);
      check("post_rst_idle",    32'(o_busy), 32'd0);
    end
    send_image(img_r, 1, 1'b0, 1'b0, img_z);

    // DIV=4 with only pixels 0 and 783 set.
    sel = 1'b1;
    @(negedge clk);
    img_b = '0;
    img_b[0] = 1'b1;
    img_b[N-1] = 1'b1;
    send_image(img_b, 4, 1'b0, 1'b0, img_z);
    sel = 1'b0;
    @(negedge clk);

    // All-ones image for the ones counter.
    img_c = '1;
    send_image(img_c, 1, 1'b0, 1'b0, img_z);
    repeat (2) @(negedge clk);
    check("ones_hold", 32'(o_ones), ones_model(img_c));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
